// File: rtl/pong_pkg.sv
// Shared pong definitions: DAC frame layout, power-down codes and the
// one-hot state encoding used by the DAC writer.
package pong_pkg;

  localparam int DAC_FRAME_BITS = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    SHIFT = 4'b0100,
    GAP   = 4'b1000
  } dac_state_e;

  // The 8-bit sample lands in the top of the 12-bit DAC code.
  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(input logic [1:0] pd,
                                                          input logic [7:0] sample);
    return {2'b00, pd, sample, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_spi_writer_if.sv
// Sample-pair handshake between game logic (master) and the DAC writer (slave).
interface dac_spi_writer_if;
  logic [7:0] value_a;
  logic [7:0] value_b;
  logic       valid;
  logic       ready;
  logic       done;

  modport master (output value_a, value_b, valid, input ready, done);
  modport slave  (input value_a, value_b, valid, output ready, done);
endinterface

// File: rtl/dac_spi_writer_half_tick_gen.sv
// Free-running divider that ticks once every CLK_DIV cycles; clear restarts
// the count so the first tick after a state change lands exactly CLK_DIV later.
module half_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int               DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                         div_cnt <= '0;
    else if (clear || div_cnt == LAST) div_cnt <= '0;
    else                               div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises 8-bit sample pairs into 16-bit frames for a dual DAC121S101
// (Pmod DA2): shared SYNC/SCLK, separate DINA/DINB, data changes on SCLK rise.
module dac_spi_writer
  import pong_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         GAP_CYCLES = 2,
  parameter logic [1:0] PD_MODE    = PD_NORMAL
) (
  input  logic             sys_clk,
  input  logic             reset,
  dac_spi_writer_if.slave  host,
  output logic             sync_n,
  output logic             sclk,
  output logic             dina,
  output logic             dinb
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  dac_state_e                 state, state_nxt;
  logic                       tick;
  logic                       sclk_hi;
  logic [3:0]                 bit_cnt;
  logic [DAC_FRAME_BITS-1:0]  sh_a, sh_b;
  logic [GAP_W-1:0]           gap_cnt;
  logic                       xfer;
  logic                       bit_rise;

  assign xfer     = (state == IDLE) && host.valid;
  assign bit_rise = (state == SHIFT) && tick && !sclk_hi && (bit_cnt != 4'd0);

  half_tick_gen #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clear   (state_nxt != state),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The bit-0 low phase ends the frame instead of producing another rise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host.valid) state_nxt = LOAD;
      LOAD:    if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && !sclk_hi && bit_cnt == 4'd0) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sh_a    <= '0;
      sh_b    <= '0;
      bit_cnt <= '0;
      sclk_hi <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (xfer) begin
        sh_a    <= dac_frame(PD_MODE, host.value_a);
        sh_b    <= dac_frame(PD_MODE, host.value_b);
        bit_cnt <= 4'd15;
      end else if (bit_rise) begin
        sh_a    <= {sh_a[DAC_FRAME_BITS-2:0], 1'b0};
        sh_b    <= {sh_b[DAC_FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end

      if (state != SHIFT) sclk_hi <= 1'b0;
      else if (tick)      sclk_hi <= !sclk_hi;

      if (state != GAP) gap_cnt <= '0;
      else              gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_comb begin
    host.ready = 1'b0;
    host.done  = 1'b0;
    sync_n     = 1'b1;
    sclk       = 1'b1;
    dina       = 1'b0;
    dinb       = 1'b0;
    case (state)
      IDLE:  host.ready = 1'b1;
      LOAD: begin
        sync_n = 1'b0;
        dina   = sh_a[DAC_FRAME_BITS-1];
        dinb   = sh_b[DAC_FRAME_BITS-1];
      end
      SHIFT: begin
        sync_n = 1'b0;
        sclk   = sclk_hi;
        dina   = sh_a[DAC_FRAME_BITS-1];
        dinb   = sh_b[DAC_FRAME_BITS-1];
      end
      GAP:     host.done = (gap_cnt == '0);
      default: ;
    endcase
  end

endmodule
